// File: rtl/display_scan_driver_if.sv
// Display/tone bus between the alarm-clock compute block, the scan driver and the board pins.
// The master drives the time word and ring request. The slave drives the display and speaker pins.
interface display_scan_driver_if;
  logic [10:0] display_i;
  logic        ring_i;
  logic [6:0]  seg_o;
  logic [3:0]  dig_sel_o;
  logic        am_pm_led_o;
  logic        speaker_o;

  modport master (
    output display_i, ring_i,
    input  seg_o, dig_sel_o, am_pm_led_o, speaker_o
  );

  modport slave (
    input  display_i, ring_i,
    output seg_o, dig_sel_o, am_pm_led_o, speaker_o
  );
endinterface

// File: rtl/display_scan_driver.sv
// 4-digit multiplexed 7-segment scan driver with per-frame snapshot and a piezo tone generator.
// Optional build macro LEADING_ZERO_BLANK_EN: blanks the hours-tens digit when it is zero.
module display_scan_driver #(
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned TONE_DIV = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  display_scan_driver_if.slave  bus
);

  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    idx_q, idx_d;
  logic [10:0]   frame_q, frame_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    dig_q, dig_d;
  logic          ampm_q, ampm_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          spk_q, spk_d;
  logic          ring_q, ring_d;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b0111111;
      4'd1:    g = 7'b0000110;
      4'd2:    g = 7'b1011011;
      4'd3:    g = 7'b1001111;
      4'd4:    g = 7'b1100110;
      4'd5:    g = 7'b1101101;
      4'd6:    g = 7'b1111101;
      4'd7:    g = 7'b0000111;
      4'd8:    g = 7'b1111111;
      4'd9:    g = 7'b1101111;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  // Glyph for digit k of a frame word; out-of-range times show dashes on every digit
  function automatic logic [6:0] frame_glyph(input logic [10:0] w, input logic [1:0] k);
    logic [3:0] hrs;
    logic [5:0] mins;
    logic [3:0] dig;
    logic [6:0] g;
    hrs  = w[9:6];
    mins = w[5:0];
    case (k)
      2'd0:    dig = (hrs >= 4'd10) ? 4'd1 : 4'd0;
      2'd1:    dig = (hrs >= 4'd10) ? hrs - 4'd10 : hrs;
      2'd2:    dig = 4'(mins / 6'd10);
      default: dig = 4'(mins % 6'd10);
    endcase
    g = seg7(dig);
`ifdef LEADING_ZERO_BLANK_EN
    if (k == 2'd0 && dig == 4'd0) g = 7'b0000000;
`endif
    if (hrs == 4'd0 || hrs > 4'd12 || mins > 6'd59) g = 7'b1000000;
    return g;
  endfunction

  // Scan path: slot_q/idx_q name the slot position the next edge produces
  always_comb begin
    slot_d  = slot_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    seg_d   = seg_q;
    dig_d   = dig_q;
    ampm_d  = ampm_q;

    if (slot_q == SW'(0)) begin
      if (idx_q == 2'd0) frame_d = bus.display_i;
      seg_d  = frame_glyph(frame_d, idx_q);
      ampm_d = frame_d[10];
      dig_d  = 4'b0000;
    end else begin
      dig_d = 4'(4'b0001 << idx_q);
    end

    if (slot_q == SW'(SCAN_DIV - 1)) begin
      slot_d = SW'(0);
      idx_d  = idx_q + 2'd1;
    end else begin
      slot_d = slot_q + SW'(1);
    end
  end

  // Tone path: first high sample arms the counter, a low sample kills the tone at once
  always_comb begin
    tcnt_d = tcnt_q;
    spk_d  = spk_q;
    ring_d = ring_q;

    if (!bus.ring_i) begin
      tcnt_d = TW'(0);
      spk_d  = 1'b0;
      ring_d = 1'b0;
    end else if (!ring_q) begin
      tcnt_d = TW'(0);
      ring_d = 1'b1;
    end else if (tcnt_q == TW'(TONE_DIV - 1)) begin
      tcnt_d = TW'(0);
      spk_d  = ~spk_q;
    end else begin
      tcnt_d = tcnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= SW'(0);
      idx_q   <= 2'd0;
      frame_q <= 11'd0;
      seg_q   <= 7'd0;
      dig_q   <= 4'd0;
      ampm_q  <= 1'b0;
      tcnt_q  <= TW'(0);
      spk_q   <= 1'b0;
      ring_q  <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      ampm_q  <= ampm_d;
      tcnt_q  <= tcnt_d;
      spk_q   <= spk_d;
      ring_q  <= ring_d;
    end
  end

  assign bus.seg_o       = seg_q;
  assign bus.dig_sel_o   = dig_q;
  assign bus.am_pm_led_o = ampm_q;
  assign bus.speaker_o   = spk_q;

endmodule

// File: doc/display_scan_driver.md
# display_scan_driver

Output stage directly downstream of the alarm-clock compute block. It consumes the 11-bit display bus (AM/PM, hours, minutes) and the speaker enable. It drives a 4-digit multiplexed 7-segment display plus an AM/PM LED, and generates a square-wave tone for the piezo speaker while the ring request is active. Each frame is snapshotted so that a time update mid-scan never tears the shown value.

## Interface
- SCAN_DIV, 4: clock cycles per digit slot; legal range ≥2.
- TONE_DIV, 8: clock cycles per speaker half-period; legal range ≥1.
- CLK  in  1  single clock; all state changes on the rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- DISPLAY_IN  in  11  bus fields:
  - [10] AM_PM: 1 = PM.
  - [9:6] hours, binary, valid 1..12.
  - [5:0] minutes, binary, valid 0..59.
- RING_IN  in  1  tone request, level-sensitive.
- SEG  out  7  segment pattern gfedcba, i.e. SEG[6] = g, active-high.
- DIG_SEL  out  4  one-hot digit enable, active-high; bit 0 = hours tens (leftmost), bit 3 = minutes units.
- AM_PM_LED  out  1  AM_PM bit of the current frame.
- SPEAKER  out  1  tone output.

## Operation
- Reset values:
  - Outputs: SEG = 0, DIG_SEL = 0000, AM_PM_LED = 0, SPEAKER = 0.
  - Internal state: slot counter, digit index, tone counter and frame register all cleared.
- Scan sequence:
  - Digit index runs 0→1→2→3→0. Each slot lasts exactly SCAN_DIV cycles.
  - Slot cycle 0 is a guard cycle: DIG_SEL = 0000 and SEG already carries digit k's pattern.
  - Slot cycles 1..SCAN_DIV-1: DIG_SEL = one-hot(k), SEG unchanged.
- Frame capture:
  - DISPLAY_IN is sampled into the frame register on the edge that begins slot 0. This includes the first active edge after reset.
  - Slot 0's SEG pattern and AM_PM_LED come from that same sample.
  - All four digits of a frame come from one sample. Changes on DISPLAY_IN between captures are ignored.
- Digit decode:
  - Hours tens = 1 if hours ≥ 10, else 0; hours units = hours mod 10.
  - Minutes tens = minutes / 10; minutes units = minutes mod 10.
  - Standard 7-segment glyphs, with 7 including segment f is not required: 7 = abc.
- Invalid frame: if hours is 0 or greater than 12, or minutes is greater than 59, every digit of that frame shows a dash (SEG = 1000000). AM_PM_LED still follows bit 10.
- Tone generator:
  - While RING_IN is sampled high, the tone counter runs 0..TONE_DIV-1 and wraps.
  - SPEAKER toggles on each edge where the counter is at TONE_DIV-1, giving a 2·TONE_DIV period.
  - The first edge that samples RING_IN high loads the counter with 0; SPEAKER stays 0 on that edge.
  - On an edge sampling RING_IN low, SPEAKER is forced to 0 and the counter is cleared, regardless of phase.
- The scan path and the tone path are independent; neither one stalls the other.
- Reset asserted mid-frame or mid-tone: all outputs return to their reset values immediately (asynchronously). After release, scanning restarts at slot 0 with a fresh capture.

## Timing
- All outputs are registered; nothing is driven combinationally from inputs.
- Capture-to-display latency: one edge. The capturing edge also produces the slot-0 guard cycle.
- Frame length: 4·SCAN_DIV cycles. DISPLAY_IN is sampled exactly once per frame.
- Frame boundary: the slot 3 → slot 0 transition is a single edge. DIG_SEL goes from 1000 to 0000, and SEG and AM_PM_LED update on that same edge.
- RING_IN rising: the first SPEAKER rise comes TONE_DIV edges after the capturing edge.
- RING_IN falling: SPEAKER is 0 one edge later.

## Configuration
- LEADING_ZERO_BLANK_EN:
  - Defined: when hours tens = 0 in a valid frame, SEG = 0000000 throughout slot 0. DIG_SEL timing is unchanged.
  - Undefined: a "0" glyph (0111111) is shown in slot 0.
  - Invalid frames show dashes in both builds.

## Test plan
- Reset/first frame (SCAN_DIV=4): hold RESETN low, with DISPLAY_IN = {1, 4'd12, 6'd34}.
  - While in reset: all outputs are 0.
  - After release: the first edge gives DIG_SEL = 0000, SEG = 0000110 ("1"), AM_PM_LED = 1.
  - The next 3 cycles give DIG_SEL = 0001; then slot 1 shows "2", slot 2 "3", slot 3 "4".
- Tearing: change DISPLAY_IN from 12:34 to 12:35 during slot 2. Slot 3 still shows "4"; the next frame's slot 3 shows "5".
- Invalid: DISPLAY_IN hours = 13 or minutes = 60. All four slots show SEG = 1000000; AM_PM_LED follows bit 10.
- Leading zero: hours = 9, minutes = 5.
  - Built with LEADING_ZERO_BLANK_EN: slot 0 SEG = 0000000.
  - Built without it: slot 0 SEG = 0111111.
  - Both builds: slot 1 shows "9", slots 2/3 show "0"/"5".
- Tone (TONE_DIV=3): raise RING_IN for 20 cycles.
  - SPEAKER rises 3 edges after the capturing edge, then toggles every 3 cycles.
  - Drop RING_IN mid-high-phase: SPEAKER = 0 one edge later.
  - Re-raise RING_IN: the phase restarts from 0.
- Mid-frame reset: assert RESETN low during slot 2 with RING_IN high.
  - Outputs go to 0 without waiting for a clock edge.
  - After release, the scan restarts at slot 0 and recaptures DISPLAY_IN.
